// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready word intake, stall support,
// first/last framing and back-to-back words with no idle gap between them.
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    logic             xfer;
    logic             last_xfer;
    logic             accept;
    logic [WIDTH-1:0] sreg_adv;

    // A word may be taken while idle, or in the very cycle the final bit leaves.
    assign xfer      = (state == SHIFT) && shift_en;
    assign last_xfer = xfer && ser_last;
    assign in_ready  = rst && ((state == IDLE) || last_xfer);
    assign accept    = in_valid && in_ready;
    assign sreg_adv  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last_xfer;
            if (accept) begin
                state     <= SHIFT;
                sreg      <= in_data;
                cnt       <= CW'(WIDTH - 1);
                ser_out   <= MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
                ser_valid <= 1'b1;
                ser_first <= 1'b1;
                ser_last  <= 1'b0;
                busy      <= 1'b1;
            end else if (last_xfer) begin
                state     <= IDLE;
                ser_out   <= IDLE_LEVEL;
                ser_valid <= 1'b0;
                ser_first <= 1'b0;
                ser_last  <= 1'b0;
                busy      <= 1'b0;
            end else if (xfer) begin
                sreg      <= sreg_adv;
                cnt       <= cnt - CW'(1);
                ser_out   <= MSB_FIRST ? sreg_adv[WIDTH-1] : sreg_adv[0];
                ser_first <= 1'b0;
                ser_last  <= (cnt == CW'(1));
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a word/bit-index model of the serial stream.
module tb_piso_serializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         shift_en;

    logic rdy_m, out_m, val_m, first_m, last_m, busy_m, done_m;
    logic rdy_l, out_l, val_l, first_l, last_l, busy_l, done_l;

    int checks   = 0;
    int failures = 0;

    // Reference: is a word active, which word, how many of its bits already left.
    bit           m_active;
    bit           m_done;
    bit           m_acc;
    logic [W-1:0] m_word;
    int           m_idx;
    logic [W-1:0] col_m;
    logic [W-1:0] col_l;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .shift_en(shift_en), .ser_out(out_m), .ser_valid(val_m), .ser_first(first_m),
        .ser_last(last_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .shift_en(shift_en), .ser_out(out_l), .ser_valid(val_l), .ser_first(first_l),
        .ser_last(last_l), .busy(busy_l), .done(done_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic eb_m, eb_l, erdy, efirst, elast;
        eb_m   = m_active ? m_word[W-1-m_idx] : 1'b0;
        eb_l   = m_active ? m_word[m_idx] : 1'b0;
        efirst = m_active && (m_idx == 0);
        elast  = m_active && (m_idx == W - 1);
        erdy   = rst && (!m_active || (elast && shift_en));
        check("ser_out_m",   32'(out_m),   32'(eb_m));
        check("ser_out_l",   32'(out_l),   32'(eb_l));
        check("ser_valid_m", 32'(val_m),   32'(m_active));
        check("ser_valid_l", 32'(val_l),   32'(m_active));
        check("ser_first_m", 32'(first_m), 32'(efirst));
        check("ser_first_l", 32'(first_l), 32'(efirst));
        check("ser_last_m",  32'(last_m),  32'(elast));
        check("ser_last_l",  32'(last_l),  32'(elast));
        check("busy_m",      32'(busy_m),  32'(m_active));
        check("busy_l",      32'(busy_l),  32'(m_active));
        check("done_m",      32'(done_m),  32'(m_done));
        check("done_l",      32'(done_l),  32'(m_done));
        check("in_ready_m",  32'(rdy_m),   32'(erdy));
        check("in_ready_l",  32'(rdy_l),   32'(erdy));
        // Downstream view: reassemble each word from the bits that actually transfer.
        if (rst && m_active && shift_en) begin
            col_m = {col_m[W-2:0], out_m};
            col_l = {out_l, col_l[W-1:1]};
            if (m_idx == W - 1) begin
                check("word_m", 32'(col_m), 32'(m_word));
                check("word_l", 32'(col_l), 32'(m_word));
                col_m = '0;
                col_l = '0;
            end
        end
    endtask

    task automatic model_update();
        bit xfer, lastx;
        m_acc = 1'b0;
        if (rst) begin
            xfer   = m_active && shift_en;
            lastx  = xfer && (m_idx == W - 1);
            m_acc  = in_valid && (!m_active || lastx);
            m_done = lastx;
            if (m_acc) begin
                m_word   = in_data;
                m_idx    = 0;
                m_active = 1'b1;
            end else if (lastx) begin
                m_active = 1'b0;
            end else if (xfer) begin
                m_idx++;
            end
        end
    endtask

    // One clock: drive at the falling edge, check, let the rising edge happen.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic en);
        in_valid = v;
        in_data  = d;
        shift_en = en;
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_model();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_idx    = 0;
        m_word   = '0;
        col_m    = '0;
        col_l    = '0;
    endtask

    // Asserts reset between clock edges so the check proves it acts without a clock.
    task automatic mid_reset();
        in_valid = 1'b0;
        shift_en = 1'b1;
        #2 rst = 1'b0;
        #1 clear_model();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
    endtask

    initial begin
        bit           pend;
        logic [W-1:0] pdata;
        logic         en;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        shift_en = 1'b0;
        m_acc    = 1'b0;
        clear_model();
        #12 check_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Basic word
        cycle(1'b1, 4'b1010, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

        // Stall after the first bit
        cycle(1'b1, 4'b1010, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b1);

        // Back-to-back words
        cycle(1'b1, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0111, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

        // Order check on a word with distinct halves
        cycle(1'b1, 4'b0011, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

        // Reset in the middle of a word, then a clean word
        cycle(1'b1, 4'b1100, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);
        mid_reset();
        cycle(1'b1, 4'b0101, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0000, 1'b1);

        // in_valid toggled while not ready must be ignored
        cycle(1'b1, 4'b1001, 1'b1);
        cycle(1'b1, 4'b0110, 1'b1);
        cycle(1'b0, 4'b0110, 1'b1);
        cycle(1'b1, 4'b0110, 1'b1);
        cycle(1'b0, 4'b0110, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 4'b0000, 1'b1);

        // Random traffic with a well-behaved producer and random stalls
        pend  = 1'b0;
        pdata = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 2) != 0)) begin
                pend  = 1'b1;
                pdata = W'($urandom);
            end
            en = ($urandom_range(0, 3) != 0);
            cycle(pend, pdata, en);
            if (m_acc) pend = 1'b0;
            if (i == 200) mid_reset();
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out serializer that produces the 1-bit stream consumed by the 4-bit serial-to-parallel shift register stage. It accepts a WIDTH-bit word over a valid/ready handshake. It then emits the word one bit per enabled clock, with framing markers so the downstream stage knows word boundaries. It supports stalls and back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits (>=2)
MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first
IDLE_LEVEL, 0, value driven on ser_out when no word is active

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
in_data  input  WIDTH  parallel word to serialize
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
shift_en  input  1  downstream accepts the presented bit this cycle (0 = stall)
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out holds a valid bit
ser_first  output  1  presented bit is the first bit of a word
ser_last  output  1  presented bit is the last bit of a word
busy  output  1  a word is in flight
done  output  1  one-cycle pulse after the last bit transfers

Behaviour:
- Reset (rst=0, async): state=IDLE, ser_out=IDLE_LEVEL, ser_valid/ser_first/ser_last/busy/done=0, bit counter=0, in_ready forced 0.
- States: IDLE, SHIFT.
- Transfer rule: a bit is consumed on a rising edge where ser_valid=1 and shift_en=1.
- Accept rule: a word is accepted on a rising edge where in_valid=1 and in_ready=1.
- in_ready is combinational: 1 in IDLE; 1 in SHIFT only when ser_last=1 and shift_en=1; otherwise 0.
- IDLE -> SHIFT on accept:
  - load shift register from in_data; counter=WIDTH-1.
  - Next cycle: ser_valid=1, ser_first=1, ser_out=first bit (MSB if MSB_FIRST, else LSB).
- Latency: accept edge to first bit valid = 1 cycle.
- SHIFT, on each transfer edge:
  - advance to the next bit; decrement counter; ser_first=0.
  - ser_last=1 while counter=0, i.e. while the final bit is presented.
- SHIFT, shift_en=0: hold ser_out, ser_valid, ser_first, ser_last, counter and shift register unchanged. No bit is lost or duplicated.
- Last-bit transfer, no new word: go to IDLE; ser_valid=0, ser_out=IDLE_LEVEL, busy=0, done=1 for exactly one cycle.
- Last-bit transfer, with simultaneous accept (back-to-back):
  - stay in SHIFT; load the new word.
  - next cycle presents the new word's first bit with ser_first=1, so there is no gap.
  - done=1 in that same cycle.
- busy=1 from the cycle after accept until the cycle after the last transfer of the final queued word.
- in_valid while in_ready=0: ignored; in_data not sampled; upstream must hold in_valid/in_data until accepted.
- Words shorter or longer than WIDTH do not exist; counter width = clog2(WIDTH).
- Reset mid-word: immediate async return to reset values. The partial word is discarded and no done pulse is issued. The first accept after release starts a clean word.
- ser_out, ser_valid, ser_first, ser_last, busy and done are all registered (glitch-free for the downstream stage).

Test Plan:
1. Basic word: reset low 10 ns, release; in_data=4'b1010 with in_valid=1 for one accept; shift_en=1.
   - ser_out = 1,0,1,0 on 4 consecutive cycles; ser_first on bit 1; ser_last on bit 4.
   - done pulses the following cycle; the downstream SIPO captures 4'b1010.
2. Stall: same word, shift_en=0 for 2 cycles after the first bit transfers.
   - Second bit (0) is held for 3 cycles; total 6 valid cycles; output sequence is still 1,0,1,0; single done pulse.
3. Back-to-back: 4'b1010 accepted, then 4'b0111 held with in_valid=1.
   - in_ready high only on the 4th bit; 8 contiguous valid bits 1,0,1,0,0,1,1,1.
   - ser_first on bits 1 and 5; done pulses after bit 4 and after bit 8.
4. LSB-first: MSB_FIRST=0, in_data=4'b0011 -> ser_out = 1,1,0,0.
5. Reset mid-word: load 4'b1100, assert rst=0 after 2 bits transfer.
   - All outputs go to reset values without waiting for clk; no done pulse.
   - After release, loading 4'b0101 yields 0,1,0,1 with ser_first on the first bit.
6. Ignored input: during word 4'b1001, toggle in_valid with in_data=4'b0110 while in_ready=0, then drop it before the last bit.
   - Output is exactly 1,0,0,1; block returns to IDLE; 4'b0110 is never emitted.
